// File: rtl/gmii_rx_mac_pkg.sv
`default_nettype none
// ==[ gmii_rx_mac_pkg | shared Ethernet Rx constants, FSM states, helpers | rev 1.0 ]==
package gmii_rx_mac_pkg;

  localparam logic [7:0]  ENET_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ENET_SFD         = 8'hD5;
  localparam logic [31:0] ENET_CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] ENET_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ENET_CRC_RESIDUE = 32'hC704DD7B;

  localparam int DLY_DEPTH = 5;   // 4 FCS bytes + 1 so the last payload byte is still held at !dv
  localparam int LEN_W     = 12;  // wide enough to saturate well above any MAX_FRAME

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_e;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // CRC engine shifts LSB-first, so it works on the bit-reversed polynomial.
  localparam logic [31:0] ENET_CRC_POLY_REFL = bitrev32(ENET_CRC_POLY);

endpackage
`default_nettype wire

// File: rtl/gmii_rx_mac_if.sv
`default_nettype none
// ==[ gmii_rx_mac_if | GMII Rx input bus and framed payload output bus | rev 1.0 ]==
interface gmii_rx_mac_if;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_err;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_frame_err;
  logic [10:0] rx_len;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_err,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_frame_err, rx_len
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_err,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_frame_err, rx_len
  );
endinterface
`default_nettype wire

// File: rtl/gmii_rx_mac_crc32_d8.sv
`default_nettype none
// ==[ crc32_d8 | combinational byte-wide IEEE 802.3 CRC-32 step, LSB first | rev 1.0 ]==
module crc32_d8
  import gmii_rx_mac_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ENET_CRC_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule
`default_nettype wire

// File: rtl/gmii_rx_mac.sv
`default_nettype none
// ==[ gmii_rx_mac | GMII Rx framer: preamble strip, FCS check/strip, frame counters | rev 1.0 ]==
module gmii_rx_mac
  import gmii_rx_mac_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522,
  parameter int CNT_W     = 16
) (
  input  logic             clk_125mhz,
  input  logic             rst_n,
  input  logic             rx_enable_i,
  gmii_rx_mac_if.slave     bus,
  output logic [CNT_W-1:0] frames_good_o,
  output logic [CNT_W-1:0] frames_bad_o
);

  logic [7:0]       s0_rxd_q;
  logic             s0_dv_q;
  logic             s0_err_q;
  rx_state_e        state_q;
  logic [7:0]       line_q [DLY_DEPTH];
  logic [2:0]       fill_q;
  logic             first_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic             bad_d;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_sof_q;
  logic             rx_eof_q;
  logic             rx_frame_err_q;
  logic [10:0]      rx_len_q;
  logic [CNT_W-1:0] good_q;
  logic [CNT_W-1:0] bad_q;
  logic             full_w;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (s0_rxd_q),
    .crc_o  (crc_d)
  );

  assign full_w = (fill_q == 3'(DLY_DEPTH));

  // Verdict for the frame ending this cycle; an err on the closing cycle still counts.
  assign bad_d = err_q | s0_err_q | !full_w
               | (bitrev32(crc_q) != ENET_CRC_RESIDUE)
               | (len_q < LEN_W'(MIN_FRAME))
               | (len_q > LEN_W'(MAX_FRAME));

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      s0_rxd_q       <= '0;
      s0_dv_q        <= 1'b0;
      s0_err_q       <= 1'b0;
      state_q        <= ST_IDLE;
      for (int i = 0; i < DLY_DEPTH; i++) line_q[i] <= '0;
      fill_q         <= '0;
      first_q        <= 1'b0;
      crc_q          <= ENET_CRC_INIT;
      len_q          <= '0;
      err_q          <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_sof_q       <= 1'b0;
      rx_eof_q       <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_len_q       <= '0;
      good_q         <= '0;
      bad_q          <= '0;
    end else begin
      s0_rxd_q       <= bus.gmii_rxd;
      s0_dv_q        <= bus.gmii_rx_dv;
      s0_err_q       <= bus.gmii_rx_err;
      rx_valid_q     <= 1'b0;
      rx_sof_q       <= 1'b0;
      rx_eof_q       <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_len_q       <= '0;

      case (state_q)
        ST_IDLE, ST_PRE: begin
          if (!s0_dv_q) begin
            state_q <= ST_IDLE;
          end else if (s0_rxd_q == ENET_PREAMBLE) begin
            state_q <= ST_PRE;
          end else if (s0_rxd_q == ENET_SFD) begin
            if (rx_enable_i) begin
              state_q <= ST_DATA;
              crc_q   <= ENET_CRC_INIT;
              len_q   <= '0;
              fill_q  <= '0;
              err_q   <= 1'b0;
              first_q <= 1'b1;
            end else begin
              state_q <= ST_DROP;
            end
          end else begin
            state_q <= ST_DROP;
            if (!(&bad_q)) bad_q <= bad_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (s0_dv_q) begin
            for (int i = DLY_DEPTH - 1; i > 0; i--) line_q[i] <= line_q[i-1];
            line_q[0] <= s0_rxd_q;
            crc_q     <= crc_d;
            err_q     <= err_q | s0_err_q;
            if (!full_w)  fill_q <= fill_q + 3'd1;
            if (!(&len_q)) len_q <= len_q + LEN_W'(1);
            if (full_w) begin
              rx_data_q  <= line_q[DLY_DEPTH-1];
              rx_valid_q <= 1'b1;
              rx_sof_q   <= first_q;
              first_q    <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            // Oldest held byte is the last payload byte; the other four are FCS.
            if (full_w) begin
              rx_data_q      <= line_q[DLY_DEPTH-1];
              rx_valid_q     <= 1'b1;
              rx_sof_q       <= first_q;
              rx_eof_q       <= 1'b1;
              rx_frame_err_q <= bad_d;
              rx_len_q       <= (len_q > LEN_W'(2051)) ? 11'h7FF : 11'(len_q - LEN_W'(4));
            end
            first_q <= 1'b0;
            if (bad_d) begin
              if (!(&bad_q)) bad_q <= bad_q + CNT_W'(1);
            end else begin
              if (!(&good_q)) good_q <= good_q + CNT_W'(1);
            end
          end
        end

        ST_DROP: begin
          if (!s0_dv_q) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_sof       = rx_sof_q;
  assign bus.rx_eof       = rx_eof_q;
  assign bus.rx_frame_err = rx_frame_err_q;
  assign bus.rx_len       = rx_len_q;
  assign frames_good_o    = good_q;
  assign frames_bad_o     = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_mac.sv
`default_nettype none
// ==[ tb_gmii_rx_mac | directed frames against a byte-stream frame model | rev 1.0 ]==
module tb_gmii_rx_mac;

  localparam int CMAX = 3;  // counters built 2 bits wide so saturation is reachable

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       rx_enable = 1'b1;
  logic [1:0] fg;
  logic [1:0] fb;

  gmii_rx_mac_if bus ();

  gmii_rx_mac #(
    .MIN_FRAME (64),
    .MAX_FRAME (1522),
    .CNT_W     (2)
  ) dut (
    .clk_125mhz    (clk),
    .rst_n         (rst_n),
    .rx_enable_i   (rx_enable),
    .bus           (bus.slave),
    .frames_good_o (fg),
    .frames_bad_o  (fb)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
    logic [10:0] len;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  tx_q[$];
  beat_t       act_b;
  beat_t       exp_b;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          d0_cyc = -1;
  int          d0_idx = -1;
  int          good_m = 0;
  int          bad_m  = 0;
  logic [10:0] last_len = '0;
  logic        last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input logic [7:0] b[$], input int lo, input int cnt);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int k = 0; k < cnt; k++) begin
      c = c ^ {24'd0, b[lo+k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Model: classify the whole GMII byte stream and queue the payload beats it must yield.
  task automatic model_frame(input bit en, input int err_idx);
    int          i = 0;
    int          n;
    bit          bad;
    logic [31:0] f;
    d0_idx = -1;
    while (i < tx_q.size() && tx_q[i] == 8'h55) i++;
    if (i == tx_q.size()) return;
    if (tx_q[i] != 8'hD5) begin
      bad_m = sat(bad_m + 1);
      return;
    end
    if (!en) return;
    d0_idx = i + 1;
    n      = tx_q.size() - i - 1;
    bad    = (n < 64) || (n > 1522) || (err_idx > i);
    if (n >= 4) begin
      f = crc_of(tx_q, i + 1, n - 4);
      if ({tx_q[i+n], tx_q[i+n-1], tx_q[i+n-2], tx_q[i+n-3]} != f) bad = 1'b1;
    end else begin
      bad = 1'b1;
    end
    if (n >= 5) begin
      for (int k = 0; k <= n - 5; k++) begin
        exp_q.push_back('{data: tx_q[i+1+k], sof: (k == 0), eof: (k == n - 5),
                          err: (k == n - 5) && bad,
                          len: (k == n - 5) ? 11'((n - 4 > 2047) ? 2047 : n - 4) : 11'd0});
      end
    end
    if (bad) bad_m = sat(bad_m + 1);
    else     good_m = sat(good_m + 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rx_valid === 1'b1) begin
      act_b = {bus.rx_data, bus.rx_sof, bus.rx_eof, bus.rx_frame_err, bus.rx_len};
      if (act_b.eof) begin
        last_len = act_b.len;
        last_err = act_b.err;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected beat: got %h expected none", act_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (!exp_b.eof) begin
          act_b.err = 1'b0;
          act_b.len = '0;
        end
        chk("beat{data,sof,eof,err,len}", 64'(act_b), 64'(exp_b));
        if (exp_b.sof) chk("sof latency", 64'(cyc - d0_cyc), 64'd7);
      end
    end
  end

  task automatic make_frame(input int npre, input int plen, input int seed);
    logic [31:0] f;
    tx_q.delete();
    repeat (npre) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int k = 0; k < plen; k++) tx_q.push_back(8'((seed * 31 + k * 7 + k / 3) & 255));
    f = crc_of(tx_q, npre + 1, plen);
    tx_q.push_back(f[7:0]);
    tx_q.push_back(f[15:8]);
    tx_q.push_back(f[23:16]);
    tx_q.push_back(f[31:24]);
  endtask

  task automatic drive_frame(input int err_idx, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      bus.gmii_rxd    = tx_q[k];
      bus.gmii_rx_dv  = 1'b1;
      bus.gmii_rx_err = (k == err_idx);
      if (k == d0_idx) d0_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.gmii_rxd    = 8'h00;
      bus.gmii_rx_dv  = 1'b0;
      bus.gmii_rx_err = 1'b0;
    end
  endtask

  task automatic run_frame(input bit en, input int err_idx, input int idle_n);
    rx_enable = en;
    model_frame(en, err_idx);
    drive_frame(err_idx, tx_q.size());
    idle(idle_n);
  endtask

  task automatic settle();
    idle(12);
    chk("frames_good", 64'(fg), 64'(good_m));
    chk("frames_bad",  64'(fb), 64'(bad_m));
  endtask

  initial begin
    bus.gmii_rxd    = 8'h00;
    bus.gmii_rx_dv  = 1'b0;
    bus.gmii_rx_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid", 64'(bus.rx_valid), 64'd0);
    chk("reset rx_sof",   64'(bus.rx_sof), 64'd0);
    chk("reset rx_eof",   64'(bus.rx_eof), 64'd0);
    chk("reset rx_err",   64'(bus.rx_frame_err), 64'd0);
    chk("reset rx_len",   64'(bus.rx_len), 64'd0);
    chk("reset rx_data",  64'(bus.rx_data), 64'd0);
    chk("reset good",     64'(fg), 64'd0);
    chk("reset bad",      64'(fb), 64'd0);
    rst_n = 1'b1;

    tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc model pin", 64'(crc_of(tx_q, 0, 9)), 64'hCBF43926);

    make_frame(7, 60, 1); run_frame(1'b1, -1, 1); settle();
    chk("t1 len", 64'(last_len), 64'd60);
    chk("t1 err", 64'(last_err), 64'd0);
    chk("t1 good", 64'(fg), 64'd1);

    make_frame(7, 60, 1); tx_q[13] = tx_q[13] ^ 8'h10; run_frame(1'b1, -1, 1); settle();
    chk("t2 err", 64'(last_err), 64'd1);
    chk("t2 bad", 64'(fb), 64'd1);
    chk("t2 good", 64'(fg), 64'd1);

    tx_q = '{8'h55, 8'h55, 8'hA5, 8'h11, 8'h22, 8'h33}; run_frame(1'b1, -1, 1); settle();
    chk("bad preamble count", 64'(fb), 64'd2);

    make_frame(0, 60, 9); run_frame(1'b1, -1, 1); settle();
    chk("sfd-only good", 64'(fg), 64'd2);

    make_frame(7, 40, 2); run_frame(1'b1, -1, 1); settle();
    chk("runt len", 64'(last_len), 64'd40);
    chk("runt err", 64'(last_err), 64'd1);

    make_frame(7, 1519, 3); run_frame(1'b1, -1, 1); settle();
    chk("oversize len", 64'(last_len), 64'd1519);
    chk("oversize err", 64'(last_err), 64'd1);
    chk("bad saturated", 64'(fb), 64'd3);

    make_frame(7, 59, 4);   run_frame(1'b1, -1, 1); settle();
    make_frame(7, 1518, 5); run_frame(1'b1, -1, 1); settle();
    chk("max frame err", 64'(last_err), 64'd0);
    make_frame(7, 1, 6);    run_frame(1'b1, -1, 1); settle();
    make_frame(7, 0, 7);    run_frame(1'b1, -1, 1); settle();
    make_frame(7, 60, 8);   run_frame(1'b1, 20, 1); settle();
    tx_q = '{8'h55, 8'h55, 8'h55}; run_frame(1'b1, -1, 1); settle();
    make_frame(7, 60, 10);  run_frame(1'b0, -1, 1); settle();
    make_frame(7, 60, 11);  run_frame(1'b1, -1, 1);
    make_frame(7, 64, 12);  run_frame(1'b1, -1, 1); settle();

    make_frame(7, 60, 13);
    rx_enable = 1'b1;
    model_frame(1'b1, -1);
    drive_frame(-1, 30);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rx_valid", 64'(bus.rx_valid), 64'd0);
    chk("async rst rx_data",  64'(bus.rx_data), 64'd0);
    chk("async rst good",     64'(fg), 64'd0);
    chk("async rst bad",      64'(fb), 64'd0);
    exp_q.delete();
    good_m = 0;
    bad_m  = 0;
    idle(3);
    rst_n = 1'b1;
    make_frame(7, 60, 14); run_frame(1'b1, -1, 1); settle();
    chk("post-reset good", 64'(fg), 64'd1);
    for (int r = 0; r < 3; r++) begin
      make_frame(3, 60 + r, 15 + r); run_frame(1'b1, -1, 1); settle();
    end
    chk("good saturated", 64'(fg), 64'd3);

    idle(20);
    chk("leftover beats", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
